// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller in-service logic:
// OCW2 R/SL/EOI command encodings, the INTA acknowledge FSM states,
// the default level count and a one-hot to index helper.
package pic_pkg;

  localparam int PIC_N_LEVELS = 8;

  // OCW2 {R, SL, EOI} encodings
  localparam logic [2:0] EOI_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] EOI_NONSPEC      = 3'b001;
  localparam logic [2:0] EOI_NOP          = 3'b010;
  localparam logic [2:0] EOI_SPEC         = 3'b011;
  localparam logic [2:0] EOI_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] EOI_ROT_NONSPEC  = 3'b101;
  localparam logic [2:0] EOI_SET_PRI      = 3'b110;
  localparam logic [2:0] EOI_ROT_SPEC     = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK1 = 1'b1
  } ack_state_e;

  // Index of the set bit in a one-hot vector (up to 16 levels)
  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) oh2idx = 4'(i);
  endfunction

endpackage

// File: rtl/isr_priority_search.sv
// Rotating-priority search: returns the first candidate bit found when
// scanning upward from i_lowest+1 with wrap-around, skipping masked bits.
module isr_priority_search
  import pic_pkg::*;
#(
  parameter int N_LEVELS = PIC_N_LEVELS,
  parameter int LW       = $clog2(N_LEVELS)
) (
  input  logic [N_LEVELS-1:0] i_vec,
  input  logic [N_LEVELS-1:0] i_skip,
  input  logic [LW-1:0]       i_lowest,
  output logic [N_LEVELS-1:0] o_onehot,
  output logic                o_found
);

  logic [N_LEVELS-1:0] w_cand;
  logic [LW-1:0]       w_idx;

  assign w_cand = i_vec & ~i_skip;

  // Scan one full turn starting just above the lowest-priority level
  always_comb begin
    o_onehot = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= N_LEVELS; i++) begin
      w_idx = LW'((int'(i_lowest) + i) % N_LEVELS);
      if (!o_found && w_cand[w_idx]) begin
        o_found         = 1'b1;
        o_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_service_unit.sv
// In-service register for the interrupt controller. Tracks serviced levels
// across the two-pulse INTA sequence, handles normal/automatic EOI,
// specific/non-specific EOI and special mask mode.
// Optional feature macro: ISR_ROTATION_EN enables rotating priority
// (rotate commands, set-priority and rotate-in-AEOI); otherwise priority
// is fixed with level 0 highest.
module in_service_unit
  import pic_pkg::*;
#(
  parameter  int N_LEVELS = PIC_N_LEVELS,
  localparam int LW       = $clog2(N_LEVELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ack,
  input  logic [N_LEVELS-1:0] highest_priority_interrupt,
  input  logic                aeoi_mode,
  input  logic                special_mask_mode,
  input  logic [N_LEVELS-1:0] interrupt_mask,
  input  logic                eoi_valid,
  input  logic [2:0]          eoi_cmd,
  input  logic [LW-1:0]       eoi_level,
  output logic [N_LEVELS-1:0] in_service_register,
  output logic [N_LEVELS-1:0] last_serviced,
  output logic [LW-1:0]       lowest_priority,
  output logic                ack_phase
);

  ack_state_e          r_state, w_state_nxt;
  logic [N_LEVELS-1:0] r_isr, r_pending, r_last;
  logic [N_LEVELS-1:0] w_set_oh, w_aeoi_oh, w_clr_oh, w_spec_oh, w_ns_oh, w_ns_clr;
  logic                w_ns_found, w_eoi_hit, w_aeoi_fire, w_first_ack, w_level_ok;
  logic                w_do_ns, w_do_spec;
  logic [LW-1:0]       w_lowest;
`ifdef ISR_ROTATION_EN
  logic                w_do_rot, w_do_setpri, w_rot_set, w_rot_clr;
  logic [LW-1:0]       r_lowest;
  logic                r_rot_aeoi;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: each INTA pulse advances, even a spurious one
  always_comb begin
    w_state_nxt = r_state;
    if (ack) w_state_nxt = (r_state == ST_IDLE) ? ST_ACK1 : ST_IDLE;
  end

  // FSM outputs: set on first pulse, AEOI clear on second
  always_comb begin
    w_first_ack = ack && (r_state == ST_IDLE);
    w_set_oh    = w_first_ack ? highest_priority_interrupt : '0;
    w_aeoi_fire = ack && (r_state == ST_ACK1) && aeoi_mode && (|r_pending);
    w_aeoi_oh   = w_aeoi_fire ? r_pending : '0;
  end

  assign ack_phase = (r_state == ST_ACK1);

  // EOI command decode
  always_comb begin
    w_do_ns     = 1'b0;
    w_do_spec   = 1'b0;
`ifdef ISR_ROTATION_EN
    w_do_rot    = 1'b0;
    w_do_setpri = 1'b0;
    w_rot_set   = 1'b0;
    w_rot_clr   = 1'b0;
`endif
    if (eoi_valid) begin
      case (eoi_cmd)
        EOI_NONSPEC:      w_do_ns   = 1'b1;
        EOI_SPEC:         w_do_spec = 1'b1;
`ifdef ISR_ROTATION_EN
        EOI_ROT_NONSPEC:  begin w_do_ns   = 1'b1; w_do_rot = 1'b1; end
        EOI_ROT_SPEC:     begin w_do_spec = 1'b1; w_do_rot = 1'b1; end
        EOI_SET_PRI:      w_do_setpri = 1'b1;
        EOI_ROT_AEOI_SET: w_rot_set   = 1'b1;
        EOI_ROT_AEOI_CLR: w_rot_clr   = 1'b1;
`else
        EOI_ROT_NONSPEC:  w_do_ns   = 1'b1;
        EOI_ROT_SPEC:     w_do_spec = 1'b1;
        EOI_SET_PRI, EOI_ROT_AEOI_SET, EOI_ROT_AEOI_CLR: ;
`endif
        EOI_NOP:          ;
        default:          ;
      endcase
    end
  end

  isr_priority_search #(.N_LEVELS(N_LEVELS), .LW(LW)) u_search (
    .i_vec    (r_isr),
    .i_skip   (special_mask_mode ? interrupt_mask : '0),
    .i_lowest (w_lowest),
    .o_onehot (w_ns_oh),
    .o_found  (w_ns_found)
  );

  // EOI target always comes from the pre-edge ISR; a cleared bit must be set
  assign w_level_ok = (int'(eoi_level) < N_LEVELS);
  assign w_spec_oh  = w_level_ok ? (N_LEVELS'(1) << eoi_level) : '0;
  assign w_ns_clr   = w_ns_found ? w_ns_oh : '0;
  assign w_clr_oh   = w_do_ns ? w_ns_clr : (w_do_spec ? (w_spec_oh & r_isr) : '0);
  assign w_eoi_hit  = |w_clr_oh;

  // ISR, pending and last-serviced update; a same-cycle set beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isr     <= '0;
      r_pending <= '0;
      r_last    <= '0;
    end else begin
      r_isr <= (r_isr & ~w_clr_oh & ~w_aeoi_oh) | w_set_oh;
      if (w_first_ack) r_pending <= highest_priority_interrupt;
      if (w_eoi_hit)        r_last <= w_clr_oh;
      else if (w_aeoi_fire) r_last <= r_pending;
    end
  end

`ifdef ISR_ROTATION_EN
  // Priority rotation state; explicit EOI commands take precedence over AEOI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lowest   <= LW'(N_LEVELS - 1);
      r_rot_aeoi <= 1'b0;
    end else begin
      if (w_rot_set)      r_rot_aeoi <= 1'b1;
      else if (w_rot_clr) r_rot_aeoi <= 1'b0;
      if (w_do_rot && w_eoi_hit)           r_lowest <= LW'(oh2idx(16'(w_clr_oh)));
      else if (w_do_setpri && w_level_ok)  r_lowest <= eoi_level;
      else if (w_aeoi_fire && r_rot_aeoi)  r_lowest <= LW'(oh2idx(16'(r_pending)));
    end
  end
  assign w_lowest = r_lowest;
`else
  assign w_lowest = LW'(N_LEVELS - 1);
`endif

  assign in_service_register = r_isr;
  assign last_serviced       = r_last;
  assign lowest_priority     = w_lowest;

endmodule

// File: tb/tb_in_service_unit.sv
// Directed bench for in_service_unit: expectations are queued when a step
// is driven and popped/compared one time unit after the following edge.
module tb_in_service_unit;

  localparam int N  = 8;
  localparam int LW = 3;
`ifdef ISR_ROTATION_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    string          tag;
    logic [N-1:0]   isr;
    logic [N-1:0]   last;
    logic [LW-1:0]  lowp;
    logic           phase;
    bit             chk_last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic          clk = 1'b0, reset = 1'b1, ack = 1'b0;
  logic          aeoi_mode = 1'b0, special_mask_mode = 1'b0, eoi_valid = 1'b0;
  logic [N-1:0]  hpi = '0, interrupt_mask = '0;
  logic [2:0]    eoi_cmd = '0;
  logic [LW-1:0] eoi_level = '0;
  logic [N-1:0]  isr_o, last_o;
  logic [LW-1:0] lowp_o;
  logic          phase_o;
  logic [LW-1:0] lp;

  always #5 clk = ~clk;

  in_service_unit #(.N_LEVELS(N)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .ack                        (ack),
    .highest_priority_interrupt (hpi),
    .aeoi_mode                  (aeoi_mode),
    .special_mask_mode          (special_mask_mode),
    .interrupt_mask             (interrupt_mask),
    .eoi_valid                  (eoi_valid),
    .eoi_cmd                    (eoi_cmd),
    .eoi_level                  (eoi_level),
    .in_service_register        (isr_o),
    .last_serviced              (last_o),
    .lowest_priority            (lowp_o),
    .ack_phase                  (phase_o)
  );

  task automatic want(input string tag, input logic [N-1:0] isr, input logic [N-1:0] last,
                      input logic [LW-1:0] lowp, input logic phase, input bit chk_last = 1'b1);
    exp_t e;
    e.tag = tag; e.isr = isr; e.last = last; e.lowp = lowp; e.phase = phase; e.chk_last = chk_last;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (isr_o === e.isr) else begin
        errors++; $error("FAIL %s isr got %b want %b", e.tag, isr_o, e.isr);
      end
      checks++;
      assert (lowp_o === e.lowp) else begin
        errors++; $error("FAIL %s lowest got %0d want %0d", e.tag, lowp_o, e.lowp);
      end
      checks++;
      assert (phase_o === e.phase) else begin
        errors++; $error("FAIL %s ack_phase got %b want %b", e.tag, phase_o, e.phase);
      end
      if (e.chk_last) begin
        checks++;
        assert (last_o === e.last) else begin
          errors++; $error("FAIL %s last got %b want %b", e.tag, last_o, e.last);
        end
      end
    end
  endtask

  task automatic drv(input logic a, input logic [N-1:0] h, input logic ev,
                     input logic [2:0] c, input logic [LW-1:0] l);
    ack = a; hpi = h; eoi_valid = ev; eoi_cmd = c; eoi_level = l;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    check_now();
  endtask

  initial begin
    // Reset values
    #12;
    want("reset", 8'h00, 8'h00, 3'd7, 1'b0);
    check_now();
    @(negedge clk); reset = 1'b0;

    // Normal EOI
    drv(1, 8'h20, 0, 3'b000, 0); want("nrm_ack1", 8'h20, 8'h00, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("nrm_ack2", 8'h20, 8'h00, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b001, 0); want("nrm_eoi",  8'h00, 8'h20, 3'd7, 0); tick();

    // AEOI with rotate-in-AEOI
    aeoi_mode = 1'b1;
    drv(0, 8'h00, 1, 3'b100, 0); want("aeoi_rotset", 8'h00, 8'h20, 3'd7, 0); tick();
    drv(1, 8'h02, 0, 3'b000, 0); want("aeoi_ack1",   8'h02, 8'h20, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("aeoi_ack2",   8'h00, 8'h02, ROT ? 3'd1 : 3'd7, 0); tick();
    aeoi_mode = 1'b0;
    lp = ROT ? 3'd0 : 3'd7;
    drv(0, 8'h00, 1, 3'b110, 0); want("setpri0", 8'h00, 8'h02, lp, 0); tick();
    drv(0, 8'h00, 1, 3'b000, 0); want("rotclr",  8'h00, 8'h02, lp, 0); tick();

    // Rotating non-specific EOI on ISR = 10000001
    drv(1, 8'h80, 0, 3'b000, 0); want("b81_a", 8'h80, 8'h02, lp, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b81_b", 8'h80, 8'h02, lp, 0); tick();
    drv(1, 8'h01, 0, 3'b000, 0); want("b81_c", 8'h81, 8'h02, lp, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b81_d", 8'h81, 8'h02, lp, 0); tick();
    drv(0, 8'h00, 1, 3'b101, 0);
    want("rot_ns", ROT ? 8'h01 : 8'h80, ROT ? 8'h80 : 8'h01, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b011, ROT ? 3'd0 : 3'd7);
    want("spec_clr", 8'h00, ROT ? 8'h01 : 8'h80, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b011, 3'd3);
    want("spec_empty", 8'h00, ROT ? 8'h01 : 8'h80, 3'd7, 0); tick();

    // Special mask mode on ISR = 00000011
    drv(1, 8'h01, 0, 3'b000, 0); want("b03_a", 8'h01, 8'h00, 3'd7, 1, 0); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b03_b", 8'h01, 8'h00, 3'd7, 0, 0); tick();
    drv(1, 8'h02, 0, 3'b000, 0); want("b03_c", 8'h03, 8'h00, 3'd7, 1, 0); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b03_d", 8'h03, 8'h00, 3'd7, 0, 0); tick();
    special_mask_mode = 1'b1; interrupt_mask = 8'h01;
    drv(0, 8'h00, 1, 3'b001, 0); want("smm_ns",   8'h01, 8'h02, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b001, 0); want("smm_none", 8'h01, 8'h02, 3'd7, 0); tick();
    special_mask_mode = 1'b0; interrupt_mask = 8'h00;

    // Back-to-back non-specific EOIs on ISR = 00000101
    drv(1, 8'h04, 0, 3'b000, 0); want("b05_a", 8'h05, 8'h02, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b05_b", 8'h05, 8'h02, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b001, 0); want("b2b_1", 8'h04, 8'h01, 3'd7, 0); tick();
    drv(0, 8'h00, 1, 3'b001, 0); want("b2b_2", 8'h00, 8'h04, 3'd7, 0); tick();

    // Simultaneous set and clear
    drv(1, 8'h04, 0, 3'b000, 0); want("b04_a", 8'h04, 8'h04, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("b04_b", 8'h04, 8'h04, 3'd7, 0); tick();
    drv(1, 8'h01, 1, 3'b011, 3'd2); want("simul",   8'h01, 8'h04, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0);    want("simul_b", 8'h01, 8'h04, 3'd7, 0); tick();
    drv(1, 8'h01, 1, 3'b011, 3'd0); want("setwins", 8'h01, 8'h00, 3'd7, 1, 0); tick();
    drv(1, 8'h00, 0, 3'b000, 0);    want("setwins_b", 8'h01, 8'h00, 3'd7, 0, 0); tick();

    // Reset in ACK1, then a spurious acknowledge with AEOI on
    aeoi_mode = 1'b1;
    drv(1, 8'h08, 0, 3'b000, 0); want("mid_ack1", 8'h09, 8'h00, 3'd7, 1, 0); tick();
    drv(0, 8'h00, 0, 3'b000, 0);
    #3 reset = 1'b1;
    #1 want("mid_reset", 8'h00, 8'h00, 3'd7, 0); check_now();
    @(negedge clk); reset = 1'b0;
    drv(1, 8'h00, 0, 3'b000, 0); want("spur_ack1", 8'h00, 8'h00, 3'd7, 1); tick();
    drv(1, 8'h00, 0, 3'b000, 0); want("spur_ack2", 8'h00, 8'h00, 3'd7, 0); tick();
    drv(0, 8'h00, 0, 3'b000, 0);
    aeoi_mode = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL sb_drain left %0d want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_service_unit.md
# in_service_unit

Parametrised, clocked in-service register (ISR) for the interrupt controller, generalised to N priority levels. Tracks which levels are being serviced across the two-pulse INTA acknowledge sequence. Supports normal and automatic EOI, non-specific and specific EOI, special mask mode, and rotating priority. Sits between the priority resolver, which supplies the winning request, and the control logic, which issues acknowledge strobes and EOI commands.

## Interface
- `N_LEVELS`, default 8: number of interrupt levels; legal range 2..16.
- `LW`, default `$clog2(N_LEVELS)`: level index width. Derived; not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `ack` in 1: one-cycle strobe per INTA pulse.
- `highest_priority_interrupt` in N_LEVELS: one-hot winning request from the resolver; all-zero means none.
- `aeoi_mode` in 1: 1 selects automatic EOI.
- `special_mask_mode` in 1: 1 enables special mask mode.
- `interrupt_mask` in N_LEVELS: IMR copy; used only in special mask mode.
- `eoi_valid` in 1: one-cycle strobe qualifying `eoi_cmd`.
- `eoi_cmd` in 3: OCW2 R/SL/EOI encoding.
- `eoi_level` in LW: level for specific commands.
- `in_service_register` out N_LEVELS: current ISR.
- `last_serviced` out N_LEVELS: one-hot of the last level cleared by any EOI.
- `lowest_priority` out LW: current lowest-priority level.
- `ack_phase` out 1: 1 between the first and second INTA pulses.

## Operation
- **Reset values:**
  - ISR = 0, `last_serviced` = 0.
  - `lowest_priority` = N_LEVELS-1, so level 0 has the highest priority.
  - FSM in IDLE; `rotate_in_aeoi` = 0.
- **FSM states and transitions:**
  - IDLE, on `ack`: OR `highest_priority_interrupt` into ISR and latch it as `pending`. Go to ACK1.
  - ACK1, on `ack`: if `aeoi_mode`, clear the `pending` bit and update `last_serviced`. If `rotate_in_aeoi`, also set `lowest_priority` to the `pending` index. Return to IDLE.
  - `ack_phase` = (state == ACK1).
- **Spurious acknowledge:** if `highest_priority_interrupt` is 0 on the first `ack`, ISR is unchanged, `pending` = 0, and the FSM still advances.
- **`eoi_cmd` decode** (acted on only when `eoi_valid`):
  - 001, non-specific EOI: clear the highest-priority set ISR bit, searching from `lowest_priority`+1 with wrap-around.
  - 011, specific EOI: clear bit `eoi_level`.
  - 101: rotate on non-specific EOI.
  - 111: rotate on specific EOI.
  - 110, set priority: `lowest_priority` = `eoi_level`; ISR unchanged.
  - 100: set `rotate_in_aeoi`.
  - 000: clear `rotate_in_aeoi`.
  - 010: no operation.
- **Rotation:** for rotate commands, `lowest_priority` becomes the index of the cleared bit.
- **Special mask mode:** in the non-specific search, ISR bits whose `interrupt_mask` bit is 1 are skipped.
- **EOI with no bit cleared:** if the selected ISR bit is 0, ISR, `last_serviced` and `lowest_priority` are all unchanged.
- **Out-of-range level:** `eoi_level` ≥ N_LEVELS is ignored.

## Timing
- A set or clear becomes visible on the edge after the strobe (latency 1). Outputs are registered.
- **`ack` and `eoi_valid` in the same cycle:**
  - The EOI target is computed from the pre-edge ISR.
  - If the set bit and the cleared bit are the same, the set wins.
- **Back-to-back:** EOI strobes on consecutive cycles are each applied in order.
- **Reset mid-sequence:** `reset` asserted while in ACK1 returns the FSM to IDLE with ISR = 0. No AEOI clear occurs afterwards.

## Configuration
- `ISR_ROTATION_EN` defined: rotation commands (101, 111, 110, 100/000) and the `rotate_in_aeoi` state are implemented.
- `ISR_ROTATION_EN` undefined:
  - Priority is fixed; `lowest_priority` is tied to N_LEVELS-1.
  - Commands 101 and 111 behave as 001 and 011.
  - Commands 110, 100 and 000 are no-ops.

## Structure
- **Shared package `pic_pkg`:**
  - `eoi_cmd` encodings as localparams.
  - FSM state enum (IDLE, ACK1).
  - Default `N_LEVELS`.
- **Sub-module `isr_priority_search`:** combinational rotating-priority search. Takes the vector, the skip-mask and `lowest_priority`; returns a one-hot result plus a found flag.

## Test plan
- **Reset values:** assert `reset` → ISR = 00000000, `lowest_priority` = 7, `ack_phase` = 0.
- **Normal EOI:** `aeoi_mode` = 0, `highest_priority_interrupt` = 00100000, two `ack` strobes → ISR = 00100000 after the first and still after the second. Then `eoi_cmd` = 001 → ISR = 0, `last_serviced` = 00100000.
- **AEOI with rotation:** `aeoi_mode` = 1, `eoi_cmd` = 100 issued, level 1 acknowledged → ISR bit 1 set after the first `ack`, cleared after the second; `lowest_priority` = 1.
- **Rotating non-specific EOI:** ISR = 10000001, `lowest_priority` = 0; `eoi_cmd` = 101 → bit 7 cleared, ISR = 00000001, `lowest_priority` = 7.
- **Special mask mode:** ISR = 00000011, `interrupt_mask` = 00000001; `eoi_cmd` = 001 → ISR = 00000001.
- **Simultaneous set and clear:** ISR = 00000100; `ack` with 00000001 plus specific EOI on level 2 in the same cycle → ISR = 00000001.
